// File: rtl/toy_pkg.sv
// Shared constants for the toy core: datapath widths, opcodes and fetch FSM encoding.
package toy_pkg;
  localparam int ADDR_W = 12;
  localparam int INST_W = 16;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  function automatic logic [OP_W-1:0] opcode(input logic [INST_W-1:0] inst);
    return inst[INST_W-1 -: OP_W];
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding {pc, inst} fetch entries; flush dominates push and pop.
module fetch_queue #(
  parameter  int WIDTH = 28,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            rd_ptr, wr_ptr;
  logic                        do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full queue still accepts a word when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, HALT/redirect FSM and prefetch queue feeding decode.
module fetch_unit #(
  parameter int                   ADDR_W   = toy_pkg::ADDR_W,
  parameter int                   INST_W   = toy_pkg::INST_W,
  parameter int                   DEPTH    = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter logic [3:0]           HALT_OP  = toy_pkg::OP_HALT
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [INST_W-1:0] dec_inst,
  output logic [ADDR_W-1:0] dec_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);
  import toy_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

  fetch_state_e          state;
  logic [ADDR_W-1:0]     pc;
  fq_entry_t             wr_entry, rd_entry;
  logic                  q_full, q_empty, push, pop;
  logic [$clog2(DEPTH):0] q_count;

  assign imem_addr = pc;
  assign dec_valid = (q_count != '0);
  assign dec_inst  = rd_entry.inst;
  assign dec_pc    = rd_entry.pc;
  assign pop       = !q_empty && dec_ready;
  // Redirect suppresses the push: the word at the old pc belongs to the flushed path.
  assign push      = (state == FETCH) && !redirect && (!q_full || pop);
  assign wr_entry  = '{pc: pc, inst: imem_inst};

  fetch_queue #(.WIDTH($bits(fq_entry_t)), .DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else if (redirect) begin
      state  <= FETCH;
      pc     <= redirect_pc;
      halted <= 1'b0;
    end else if (push) begin
      pc <= pc + 1'b1;
      if (imem_inst[INST_W-1 -: 4] == HALT_OP) begin
        state  <= HALTED;
        halted <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirect, HALT, PC wrap, async reset.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] imem_addr;
  logic [15:0] imem_inst;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [15:0] dec_inst;
  logic [11:0] dec_pc;
  logic        redirect = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic        halted;

  logic [15:0] imem [4096];
  int checks = 0;
  int errors = 0;

  assign imem_inst = imem[imem_addr];

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; redirect = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", dec_valid); end
    checks++; if (dec_pc !== 12'h000) begin errors++; $display("FAIL reset_pc got=%h exp=000", dec_pc); end
    checks++; if (dec_inst !== 16'h0000) begin errors++; $display("FAIL reset_inst got=%h exp=0000", dec_inst); end
    checks++; if (imem_addr !== 12'h000) begin errors++; $display("FAIL reset_addr got=%h exp=000", imem_addr); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%0b exp=0", halted); end
  endtask

  task automatic test_stream();
    apply_reset();
    dec_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== 12'(i) || dec_inst !== 16'(16'h1001 + i)) begin
        errors++;
        $display("FAIL stream[%0d] got v=%0b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                 i, dec_valid, dec_pc, dec_inst, 12'(i), 16'(16'h1001 + i));
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    dec_ready = 1'b0;
    step(10);
    checks++; if (imem_addr !== 12'h004) begin errors++; $display("FAIL bp_pc_stop got=%h exp=004", imem_addr); end
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 12'h000) begin errors++; $display("FAIL bp_head got v=%0b pc=%h exp v=1 pc=000", dec_valid, dec_pc); end
    dec_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      step();
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== 12'(i) || dec_inst !== 16'(16'h1001 + i)) begin
        errors++;
        $display("FAIL bp_drain[%0d] got v=%0b pc=%h inst=%h exp pc=%h", i, dec_valid, dec_pc, dec_inst, 12'(i));
      end
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    dec_ready = 1'b0;
    step(6);
    redirect = 1'b1; redirect_pc = 12'h0A0;
    step();
    redirect = 1'b0; dec_ready = 1'b1;
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble got v=%0b exp=0", dec_valid); end
    checks++; if (imem_addr !== 12'h0A0) begin errors++; $display("FAIL redir_pc got=%h exp=0a0", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== 12'(12'h0A0 + i) || dec_inst !== 16'(16'h10A1 + i)) begin
        errors++;
        $display("FAIL redir_stream[%0d] got v=%0b pc=%h inst=%h exp pc=%h inst=%h",
                 i, dec_valid, dec_pc, dec_inst, 12'(12'h0A0 + i), 16'(16'h10A1 + i));
      end
    end
  endtask

  task automatic test_halt();
    imem[5] = 16'hF000;
    apply_reset();
    dec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (dec_pc !== 12'(i) || halted !== (i == 5)) begin
        errors++;
        $display("FAIL halt_seq[%0d] got pc=%h halted=%0b exp pc=%h halted=%0b", i, dec_pc, halted, 12'(i), (i == 5));
      end
    end
    checks++; if (dec_inst !== 16'hF000) begin errors++; $display("FAIL halt_inst got=%h exp=f000", dec_inst); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (dec_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 12'h006) begin
        errors++;
        $display("FAIL halt_idle[%0d] got v=%0b halted=%0b addr=%h exp v=0 halted=1 addr=006", i, dec_valid, halted, imem_addr);
      end
    end
    redirect = 1'b1; redirect_pc = 12'h000;
    step();
    redirect = 1'b0;
    checks++; if (halted !== 1'b0 || dec_valid !== 1'b0) begin errors++; $display("FAIL halt_resume got halted=%0b v=%0b exp 0 0", halted, dec_valid); end
    step();
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 12'h000 || dec_inst !== 16'h1001) begin errors++; $display("FAIL halt_refetch got v=%0b pc=%h inst=%h exp v=1 pc=000 inst=1001", dec_valid, dec_pc, dec_inst); end
    imem[5] = 16'h1006;
  endtask

  task automatic test_wrap();
    logic [11:0] exp_pc [4];
    exp_pc[0] = 12'hFFE; exp_pc[1] = 12'hFFF; exp_pc[2] = 12'h000; exp_pc[3] = 12'h001;
    apply_reset();
    dec_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 12'hFFE;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== exp_pc[i] || dec_inst !== 16'(16'h1001 + exp_pc[i])) begin
        errors++;
        $display("FAIL wrap[%0d] got v=%0b pc=%h inst=%h exp pc=%h", i, dec_valid, dec_pc, dec_inst, exp_pc[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    dec_ready = 1'b0;
    step(2);
    checks++; if (dec_valid !== 1'b1 || imem_addr !== 12'h002) begin errors++; $display("FAIL ar_pre got v=%0b addr=%h exp v=1 addr=002", dec_valid, imem_addr); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dec_valid !== 1'b0 || dec_pc !== 12'h000 || dec_inst !== 16'h0000 || imem_addr !== 12'h000 || halted !== 1'b0) begin
      errors++;
      $display("FAIL ar_async got v=%0b pc=%h inst=%h addr=%h halted=%0b exp all 0", dec_valid, dec_pc, dec_inst, imem_addr, halted);
    end
    step(2);
    rst = 1'b0; dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== 12'(i)) begin
        errors++;
        $display("FAIL ar_restart[%0d] got v=%0b pc=%h exp v=1 pc=%h", i, dec_valid, dec_pc, 12'(i));
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) imem[a] = 16'(16'h1001 + a);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
